// File: rtl/mod15_counter_core.sv
// mod15_counter_core
//   Loadable up/down modulo counter (states 0..MODULUS-1, default mod-15)
//   with wrap, illegal-load and saturating wrap-count status outputs.
//
// Ports
//   clock     in   single clock, every state change on posedge
//   reset     in   asynchronous active-low clear of all state
//   load      in   1 = load data this edge (wins over counting if legal)
//   mode      in   1 = count up, 0 = count down
//   data      in   [WIDTH-1:0] load value
//   data_out  out  [WIDTH-1:0] registered count value
//   wrap      out  one-cycle pulse coincident with the wrapped data_out value
//   load_err  out  one-cycle pulse, load rejected because data >= MODULUS
//   wrap_cnt  out  [WCNT_W-1:0] wraps since reset, saturating
module mod15_counter_core #(
  parameter int MODULUS = 15,
  parameter int WIDTH   = 4,
  parameter int WCNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              mode,
  input  logic [WIDTH-1:0]  data,
  output logic [WIDTH-1:0]  data_out,
  output logic              wrap,
  output logic              load_err,
  output logic [WCNT_W-1:0] wrap_cnt
);

  // Arithmetic is one bit wider than the count so MODULUS == 2**WIDTH
  // and the legality compare both fit without overflow.
  localparam logic [WIDTH:0]    MOD_V    = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]    LAST_V   = MOD_V - (WIDTH+1)'(1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  typedef struct packed {
    logic [WIDTH:0] value;
    logic           wrap;
    logic           err;
  } nxt_t;

  generate
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("mod15_counter_core: MODULUS must be in 2..2**WIDTH");
    end
  endgenerate

  // Release path: reset rising is captured by rel_q on the first posedge,
  // and the state registers (second flop of the path) take their first
  // update on the second posedge. Assertion stays fully asynchronous.
  logic rel_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rel_q <= 1'b0;
    else        rel_q <= 1'b1;
  end

  logic [WIDTH:0] cur;
  logic           load_ok;
  logic [WIDTH:0] step_v;
  logic           step_wrap;
  nxt_t           nxt;

  always_comb begin
    cur       = {1'b0, data_out};
    load_ok   = load && ({1'b0, data} < MOD_V);
    step_v    = cur;
    step_wrap = 1'b0;
    if (mode) begin
      if (cur == LAST_V) begin
        step_v    = '0;
        step_wrap = 1'b1;
      end else begin
        step_v    = cur + (WIDTH+1)'(1);
      end
    end else begin
      if (cur == '0) begin
        step_v    = LAST_V;
        step_wrap = 1'b1;
      end else begin
        step_v    = cur - (WIDTH+1)'(1);
      end
    end

    // A rejected load falls through to a normal count step.
    nxt.value = load_ok ? {1'b0, data} : step_v;
    nxt.wrap  = !load_ok && step_wrap;
    nxt.err   = load && !load_ok;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      wrap_cnt <= '0;
    end else if (rel_q) begin
      data_out <= nxt.value[WIDTH-1:0];
      wrap     <= nxt.wrap;
      load_err <= nxt.err;
      // Counted on the same edge that raises wrap, so both move together.
      if (nxt.wrap && wrap_cnt != WCNT_MAX)
        wrap_cnt <= wrap_cnt + WCNT_W'(1);
    end
  end

  // The widened next-state value must never leave the legal range.
  a_range : assert property (@(posedge clock) disable iff (!reset)
                             nxt.value < MOD_V);

endmodule

// File: tb/tb_mod15_counter_core.sv
// Testbench for mod15_counter_core (default MODULUS=15, WIDTH=4, WCNT_W=8).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_mod15_counter_core;

  localparam int MOD = 15;
  localparam int WMAX = 255;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       mode = 1'b1;
  logic [3:0] data = 4'd0;
  logic [3:0] data_out;
  logic       wrap;
  logic       load_err;
  logic [7:0] wrap_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_val = 0;
  int m_wrap = 0;
  int m_err = 0;
  int m_cnt = 0;
  int k = 0;  // posedges since reset release

  mod15_counter_core #(.MODULUS(15), .WIDTH(4), .WCNT_W(8)) dut (
    .clock(clock), .reset(reset), .load(load), .mode(mode), .data(data),
    .data_out(data_out), .wrap(wrap), .load_err(load_err), .wrap_cnt(wrap_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    m_val = 0; m_wrap = 0; m_err = 0; m_cnt = 0; k = 0;
  endtask

  // Drive one cycle of inputs, advance the model on the posedge,
  // return on the following negedge.
  task automatic tick(input logic l, input logic m, input logic [3:0] d);
    load = l; mode = m; data = d;
    @(posedge clock);
    if (reset) begin
      k++;
      if (k >= 2) begin
        if (l && int'(d) < MOD) begin
          m_val = int'(d); m_wrap = 0; m_err = 0;
        end else begin
          m_err = l ? 1 : 0;
          if (m) begin
            m_wrap = (m_val == MOD - 1) ? 1 : 0;
            m_val  = (m_val + 1) % MOD;
          end else begin
            m_wrap = (m_val == 0) ? 1 : 0;
            m_val  = (m_val + MOD - 1) % MOD;
          end
        end
        if (m_wrap == 1 && m_cnt < WMAX) m_cnt++;
      end
    end
    @(negedge clock);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0; mode = 1'b1; load = 1'b0; data = 4'd0;
    repeat (3) @(negedge clock);
    checks++;
    if (data_out !== 4'd0 || wrap !== 1'b0 || load_err !== 1'b0 || wrap_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got out=%0d wrap=%b err=%b cnt=%0d, want all 0",
               data_out, wrap, load_err, wrap_cnt);
    end
    release_reset();
    tick(1'b0, 1'b1, 4'd0);
    checks++;
    if (data_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_first_edge_hold: got %0d want 0", data_out);
    end
    for (int i = 1; i <= 15; i++) begin
      tick(1'b0, 1'b1, 4'd0);
      checks++;
      if (data_out !== 4'(i % 15) || wrap !== (i == 15)) begin
        errors++;
        $display("FAIL reset_count_up[%0d]: got out=%0d wrap=%b want out=%0d wrap=%b",
                 i, data_out, wrap, i % 15, (i == 15));
      end
    end
    checks++;
    if (wrap_cnt !== 8'd1) begin
      errors++;
      $display("FAIL reset_wrap_cnt: got %0d want 1", wrap_cnt);
    end
  endtask

  task automatic test_load_down();
    int exp_seq [7] = '{4, 3, 2, 1, 0, 14, 13};
    int cnt0;
    tick(1'b1, 1'b0, 4'd4);
    cnt0 = m_cnt;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick(1'b0, 1'b0, 4'd0);
      checks++;
      if (data_out !== 4'(exp_seq[i]) || wrap !== (i == 5)) begin
        errors++;
        $display("FAIL load_down[%0d]: got out=%0d wrap=%b want out=%0d wrap=%b",
                 i, data_out, wrap, exp_seq[i], (i == 5));
      end
    end
    checks++;
    if (int'(wrap_cnt) !== cnt0 + 1) begin
      errors++;
      $display("FAIL load_down_wrap_cnt: got %0d want %0d", wrap_cnt, cnt0 + 1);
    end
  endtask

  task automatic test_illegal_load();
    logic [7:0] cnt0;
    tick(1'b1, 1'b1, 4'd9);
    cnt0 = wrap_cnt;
    tick(1'b1, 1'b1, 4'd15);
    checks++;
    if (data_out !== 4'd10 || load_err !== 1'b1 || wrap !== 1'b0 || wrap_cnt !== cnt0) begin
      errors++;
      $display("FAIL illegal_load: got out=%0d err=%b wrap=%b cnt=%0d want out=10 err=1 wrap=0 cnt=%0d",
               data_out, load_err, wrap, wrap_cnt, cnt0);
    end
    tick(1'b0, 1'b1, 4'd0);
    checks++;
    if (data_out !== 4'd11 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_load_pulse: got out=%0d err=%b want out=11 err=0", data_out, load_err);
    end
    // Illegal load at the top of the range still wraps on the count step.
    tick(1'b1, 1'b1, 4'd14);
    tick(1'b1, 1'b1, 4'd15);
    checks++;
    if (data_out !== 4'd0 || wrap !== 1'b1 || load_err !== 1'b1 || wrap_cnt !== cnt0 + 8'd1) begin
      errors++;
      $display("FAIL illegal_load_wrap: got out=%0d wrap=%b err=%b cnt=%0d want 0 1 1 %0d",
               data_out, wrap, load_err, wrap_cnt, cnt0 + 8'd1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom));
      checks++;
      if (int'(data_out) !== m_val || int'(wrap) !== m_wrap ||
          int'(load_err) !== m_err || int'(wrap_cnt) !== m_cnt) begin
        errors++;
        $display("FAIL random[%0d]: got out=%0d wrap=%b err=%b cnt=%0d want %0d %0d %0d %0d",
                 i, data_out, wrap, load_err, wrap_cnt, m_val, m_wrap, m_err, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    int bad = 0;
    for (int i = 0; i < 256 * 15 + 20; i++) begin
      tick(1'b0, 1'b1, 4'd0);
      if (int'(data_out) !== m_val || int'(wrap_cnt) !== m_cnt) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL saturation_track: %0d cycles disagreed with model, want 0", bad);
    end
    checks++;
    if (wrap_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturation_value: got %0d want 255", wrap_cnt);
    end
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 4'd0);
    checks++;
    if (wrap_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturation_hold: got %0d want 255", wrap_cnt);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b1, 4'd7);
    checks++;
    if (data_out !== 4'd7) begin
      errors++;
      $display("FAIL async_setup: got %0d want 7", data_out);
    end
    load = 1'b1; data = 4'd3; mode = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (data_out !== 4'd0 || wrap !== 1'b0 || load_err !== 1'b0 || wrap_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_now: got out=%0d wrap=%b err=%b cnt=%0d want all 0",
               data_out, wrap, load_err, wrap_cnt);
    end
    @(posedge clock); #1;
    checks++;
    if (data_out !== 4'd0) begin
      errors++;
      $display("FAIL async_reset_hold: got %0d want 0", data_out);
    end
    @(negedge clock);
    release_reset();
    tick(1'b1, 1'b1, 4'd3);
    tick(1'b1, 1'b1, 4'd3);
    checks++;
    if (data_out !== 4'd3 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_relaunch: got out=%0d err=%b want out=3 err=0", data_out, load_err);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] cnt0;
    cnt0 = wrap_cnt;
    tick(1'b1, 1'b1, 4'd14);
    checks++;
    if (data_out !== 4'd14 || wrap !== 1'b0 || wrap_cnt !== cnt0) begin
      errors++;
      $display("FAIL load_14: got out=%0d wrap=%b cnt=%0d want 14 0 %0d", data_out, wrap, wrap_cnt, cnt0);
    end
    tick(1'b0, 1'b1, 4'd0);
    checks++;
    if (data_out !== 4'd0 || wrap !== 1'b1 || wrap_cnt !== cnt0 + 8'd1) begin
      errors++;
      $display("FAIL up_wrap_from_14: got out=%0d wrap=%b cnt=%0d want 0 1 %0d",
               data_out, wrap, wrap_cnt, cnt0 + 8'd1);
    end
    tick(1'b1, 1'b0, 4'd0);
    checks++;
    if (data_out !== 4'd0 || wrap !== 1'b0 || wrap_cnt !== cnt0 + 8'd1) begin
      errors++;
      $display("FAIL load_0: got out=%0d wrap=%b cnt=%0d want 0 0 %0d",
               data_out, wrap, wrap_cnt, cnt0 + 8'd1);
    end
  endtask

  initial begin
    test_reset();
    test_load_down();
    test_illegal_load();
    test_boundary();
    test_random();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
